pipeline_stage_reg: RTL and testbench

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

---
 rtl/pipeline_pkg.sv | 36 +++
 rtl/pipe_slot.sv | 37 +++
 rtl/pipeline_stage_reg.sv | 106 ++++++++++
 tb/tb_pipeline_stage_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared widths, payload layout and slot-update encoding for the pipeline stage register.
package pipeline_pkg;

  localparam int DATA_W_DEF = 68;
  localparam int SIG_SIZE   = 16;
  localparam int SQ_W_DEF   = 3;

  // Payload field offsets, LSB of each field within the packed DATA_W word.
  localparam int RD_LSB   = 0;
  localparam int RT_LSB   = 2;
  localparam int IMM_LSB  = 4;
  localparam int RD2_LSB  = 20;
  localparam int RD1_LSB  = 36;
  localparam int PC_LSB   = 52;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] read_data1;
    logic [15:0] read_data2;
    logic [15:0] imm;
    logic [1:0]  rt;
    logic [1:0]  rd;
  } payload_t;

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_LOAD_IN,
    SLOT_LOAD_SKID,
    SLOT_CLEAR
  } slot_op_e;

  function automatic logic slot_loads(input slot_op_e op);
    return (op == SLOT_LOAD_IN) || (op == SLOT_LOAD_SKID);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the stage: payload, control bundle and valid flag with load and clear.
module pipe_slot
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIG_W  = SIG_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [SIG_W-1:0]  d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [SIG_W-1:0]  q_ctrl,
  output logic              q_valid
);

  // NOTE: payload is reset along with valid so a freshly reset stage reads as all-zero nops.
  // NOTE: sequential state uses <= only so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_data  <= '0;
      q_ctrl  <= '0;
      q_valid <= 1'b0;
    end else if (clear) begin
      q_data  <= '0;
      q_ctrl  <= '0;
      q_valid <= 1'b0;
    end else if (load) begin
      q_data  <= d_data;
      q_ctrl  <= d_ctrl;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stage_reg.sv
// Two-entry (head + skid) valid/ready pipeline register with flush and a timed squash window.
module pipeline_stage_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIG_W  = SIG_SIZE,
  parameter int SQ_W   = SQ_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIG_W-1:0]  in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SIG_W-1:0]  out_ctrl,
  input  logic              flush,
  input  logic              squash_req,
  input  logic [SQ_W-1:0]   squash_len,
  output logic              squash_active
);

  logic [DATA_W-1:0] head_data, skid_data, head_d_data;
  logic [SIG_W-1:0]  head_ctrl, skid_ctrl, head_d_ctrl;
  logic              head_valid, skid_valid;
  logic [SQ_W-1:0]   sq_cnt;
  logic              squashing, accept, store, pop;
  slot_op_e          head_op, skid_op;

  assign squashing = (sq_cnt != '0);
  assign in_ready  = ~skid_valid & ~reset;
  assign accept    = in_valid & in_ready;
  // Beats accepted inside the squash window are consumed but never stored.
  assign store     = accept & ~squashing;
  assign pop       = head_valid & out_ready;

  // NOTE: both ops get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    head_op = SLOT_HOLD;
    skid_op = SLOT_HOLD;
    if (flush) begin
      head_op = SLOT_CLEAR;
      skid_op = SLOT_CLEAR;
    end else if (pop) begin
      if (skid_valid) begin
        head_op = SLOT_LOAD_SKID;
        skid_op = SLOT_CLEAR;
      end else if (store) begin
        head_op = SLOT_LOAD_IN;
      end else begin
        head_op = SLOT_CLEAR;
      end
    end else if (store) begin
      if (!head_valid) head_op = SLOT_LOAD_IN;
      else             skid_op = SLOT_LOAD_IN;
    end
  end

  always_comb begin
    head_d_data = in_data;
    head_d_ctrl = in_ctrl;
    if (head_op == SLOT_LOAD_SKID) begin
      head_d_data = skid_data;
      head_d_ctrl = skid_ctrl;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .SIG_W(SIG_W)) head (
    .clk     (clk),
    .reset   (reset),
    .load    (slot_loads(head_op)),
    .clear   (head_op == SLOT_CLEAR),
    .d_data  (head_d_data),
    .d_ctrl  (head_d_ctrl),
    .q_data  (head_data),
    .q_ctrl  (head_ctrl),
    .q_valid (head_valid)
  );

  pipe_slot #(.DATA_W(DATA_W), .SIG_W(SIG_W)) skid (
    .clk     (clk),
    .reset   (reset),
    .load    (slot_loads(skid_op)),
    .clear   (skid_op == SLOT_CLEAR),
    .d_data  (in_data),
    .d_ctrl  (in_ctrl),
    .q_data  (skid_data),
    .q_ctrl  (skid_ctrl),
    .q_valid (skid_valid)
  );

  // A new request reloads rather than extends; length 0 leaves the countdown alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              sq_cnt <= '0;
    else if (squash_req && squash_len != '0) sq_cnt <= squash_len;
    else if (squashing)                     sq_cnt <= sq_cnt - SQ_W'(1);
  end

  assign squash_active = squashing;
  assign out_valid     = head_valid;
  assign out_data      = head_valid ? head_data : '0;
  assign out_ctrl      = head_valid ? head_ctrl : '0;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_pipeline_stage_reg;
  import pipeline_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int CW = SIG_SIZE;
  localparam int QW = SQ_W_DEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic          flush, squash_req, squash_active;
  logic [QW-1:0] squash_len;

  pipeline_stage_reg #(.DATA_W(DW), .SIG_W(CW), .SQ_W(QW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_ctrl       (in_ctrl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_ctrl      (out_ctrl),
    .flush         (flush),
    .squash_req    (squash_req),
    .squash_len    (squash_len),
    .squash_active (squash_active)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a bounded FIFO of at most two beats plus a squash countdown.
  logic [DW-1:0] mq[$];
  int            m_cnt;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          exp_ov;
    logic [DW-1:0] exp_d;
    logic          exp_ir;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return d[CW-1:0] ^ d[DW-1 -: CW] ^ 16'hA5C3;
  endfunction

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic sr, input logic [QW-1:0] sl);
    in_valid   = iv;
    in_data    = d;
    in_ctrl    = ctrl_of(d);
    out_ready  = ordy;
    flush      = fl;
    squash_req = sr;
    squash_len = sl;
  endtask

  // Advance one clock; model updates from the pre-edge inputs, outputs are then sampled at edge+1.
  task automatic cycle();
    bit            m_pop, m_store;
    logic [DW-1:0] t;
    m_pop   = (mq.size() > 0) && out_ready;
    m_store = in_valid && (mq.size() < 2) && (m_cnt == 0);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (m_pop) t = mq.pop_front();
      if (m_store) mq.push_back(in_data);
    end
    if (squash_req && squash_len != 0) m_cnt = int'(squash_len);
    else if (m_cnt > 0) m_cnt--;
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [DW-1:0] ed;
    ed = (mq.size() > 0) ? mq[0] : '0;
    check({tag, ".out_valid"}, out_valid, mq.size() > 0);
    check({tag, ".out_data"}, out_data, ed);
    check({tag, ".out_ctrl"}, out_ctrl, (mq.size() > 0) ? ctrl_of(ed) : '0);
    check({tag, ".in_ready"}, in_ready, mq.size() < 2);
    check({tag, ".squash_active"}, squash_active, m_cnt != 0);
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [DW-1:0] d, input logic ir);
    check({tag, ".out_valid"}, out_valid, ov);
    check({tag, ".out_data"}, out_data, ov ? d : '0);
    check({tag, ".out_ctrl"}, out_ctrl, ov ? ctrl_of(d) : '0);
    check({tag, ".in_ready"}, in_ready, ir);
  endtask

  task automatic add_vec(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic ov, input logic [DW-1:0] ed, input logic ir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.exp_ov = ov; v.exp_d = ed; v.exp_ir = ir;
    vecs.push_back(v);
  endtask

  initial begin
    payload_t p;
    int       active_cycles;

    // Streaming 1..8 with one-cycle latency, then drain.
    for (int k = 1; k <= 8; k++) add_vec(1'b1, DW'(k), 1'b1, 1'b1, DW'(k), 1'b1);
    add_vec(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    // Fill A, B under stall, hold 5 cycles with a pending beat, release.
    add_vec(1'b1, DW'('hA), 1'b0, 1'b1, DW'('hA), 1'b1);
    add_vec(1'b1, DW'('hB), 1'b0, 1'b1, DW'('hA), 1'b0);
    for (int k = 0; k < 5; k++) add_vec(1'b1, DW'('hD), 1'b0, 1'b1, DW'('hA), 1'b0);
    add_vec(1'b0, '0, 1'b1, 1'b1, DW'('hB), 1'b1);
    add_vec(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    mq.delete();
    m_cnt = 0;
    #3;
    check_out("reset", 1'b0, '0, 1'b0);
    check("reset.squash_active", squash_active, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("reset.in_ready_after", in_ready, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0, 1'b0, '0);
      cycle();
      check_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_d, vecs[i].exp_ir);
    end

    // Flush with both entries full drops them and the same-cycle beat.
    drive(1'b1, DW'('hA), 1'b0, 1'b0, 1'b0, '0); cycle();
    drive(1'b1, DW'('hB), 1'b0, 1'b0, 1'b0, '0); cycle();
    check_out("flush.full", 1'b1, DW'('hA), 1'b0);
    drive(1'b1, DW'('hC), 1'b0, 1'b1, 1'b0, '0); cycle();
    check_out("flush.after", 1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0); cycle();
    check_out("flush.c_dropped", 1'b0, '0, 1'b1);

    // Squash of 2 discards beats 1 and 2.
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1, QW'(2)); cycle();
    active_cycles = int'(squash_active);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, DW'(k), 1'b1, 1'b0, 1'b0, '0); cycle();
      active_cycles += int'(squash_active);
      check_out($sformatf("squash.beat%0d", k), k >= 3, DW'(k), 1'b1);
    end
    check("squash.active_cycles", active_cycles, 2);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0); cycle();
    check_out("squash.drain", 1'b0, '0, 1'b1);

    // Reload replaces the count; length 0 is a no-op.
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1, QW'(5)); cycle();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1, QW'(1)); cycle();
    check("reload.active", squash_active, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0); cycle();
    check("reload.expired", squash_active, 1'b0);
    drive(1'b1, DW'('h55), 1'b0, 1'b0, 1'b1, '0); cycle();
    check("len0.inactive", squash_active, 1'b0);
    check_out("len0.stored", 1'b1, DW'('h55), 1'b1);
    // Flush and squash together.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, QW'(1)); cycle();
    check_out("flush_sq.out", 1'b0, '0, 1'b1);
    check("flush_sq.active", squash_active, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0); cycle();
    check("flush_sq.expired", squash_active, 1'b0);

    // Asynchronous reset between edges with both entries full and squash running.
    drive(1'b1, DW'('hA), 1'b0, 1'b0, 1'b0, '0); cycle();
    drive(1'b1, DW'('hB), 1'b0, 1'b0, 1'b0, '0); cycle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, QW'(5)); cycle();
    check_out("areset.pre", 1'b1, DW'('hA), 1'b0);
    check("areset.pre_sq", squash_active, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_out("areset.during", 1'b0, '0, 1'b0);
    check("areset.sq", squash_active, 1'b0);
    mq.delete();
    m_cnt = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_out("areset.release", 1'b0, '0, 1'b1);
    drive(1'b1, DW'('h77), 1'b1, 1'b0, 1'b0, '0); cycle();
    check_out("areset.first_beat", 1'b1, DW'('h77), 1'b1);

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      p.pc = 16'($urandom); p.read_data1 = 16'($urandom); p.read_data2 = 16'($urandom);
      p.imm = 16'($urandom); p.rt = 2'($urandom); p.rd = 2'($urandom);
      drive($urandom_range(0, 9) < 7, DW'(p), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6, QW'($urandom_range(0, 7)));
      cycle();
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
